// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
// Imported by serial_adder.
package serial_adder_pkg;

  // Default operand/sum width in bits.
  localparam int SA_DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit full adder, the arithmetic core of serial_adder.
// Latency: purely combinational.
// Backpressure: none; no state, no handshake.
// Ports: a, b, cin -> s (sum bit), co (carry out).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Latency: start accepted at edge k, result and done at edge k+WIDTH; one addition per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; starts during SHIFT/DONE are dropped, never queued.
// Ports: clk, rst (sync, active-high), start/a/b/cin in; busy, done, sum, cout out;
//        ovf (signed overflow) out only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  fa_cell u_fa (
    .a   (ra_q[0]),
    .b   (rb_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy  = 1'b1;
        // Result fills from the MSB end so that after WIDTH shifts bit 0 sits at the LSB.
        res_d = {fa_s, res_q[WIDTH-1:1]};
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        c_d   = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q here is the carry into the MSB, fa_co the carry out of it.
          ovf_d   = c_q ^ fa_co;
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8 and WIDTH=4 instances).
// A timing/arithmetic model is compared against both DUTs every cycle, plus literal checks.
// Reports one summary line at the end.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 drives the WIDTH=8 instance, index 1 the WIDTH=4 instance.
  logic       st [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic       cv [2];

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (st[0]),
    .a     (av[0]),
    .b     (bv[0]),
    .cin   (cv[0]),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf8),
`endif
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (st[1]),
    .a     (av[1][3:0]),
    .b     (bv[1][3:0]),
    .cin   (cv[1]),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf4),
`endif
    .cout  (cout4)
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  function automatic int wid(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  // Signed overflow of a + b + cin for a w-bit two's complement operand pair.
  function automatic bit sovf(int w, logic [7:0] x, logic [7:0] y, logic c);
    int sx, sy, t;
    sx = int'(x);
    sy = int'(y);
    if (sx >= (1 << (w - 1))) sx = sx - (1 << w);
    if (sy >= (1 << (w - 1))) sy = sy - (1 << w);
    t = sx + sy + int'(c);
    return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: transaction age since accepted start ----------------
  bit         act     [2];
  int         age     [2];
  logic [8:0] exp_res [2];
  bit         exp_ovf [2];
  logic [8:0] m_res   [2];
  bit         m_ovf   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i]   <= 1'b0;
        age[i]   <= 0;
        m_res[i] <= '0;
        m_ovf[i] <= 1'b0;
      end else if (act[i]) begin
        age[i] <= age[i] + 1;
        if (age[i] + 1 == wid(i)) begin
          m_res[i] <= exp_res[i];
          m_ovf[i] <= exp_ovf[i];
        end
        if (age[i] + 1 == wid(i) + 1) act[i] <= 1'b0;
      end else if (st[i]) begin
        act[i]     <= 1'b1;
        age[i]     <= 0;
        exp_res[i] <= 9'(av[i]) + 9'(bv[i]) + 9'(cv[i]);
        exp_ovf[i] <= sovf(wid(i), av[i], bv[i], cv[i]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", 32'(busy8), 32'(act[0] && age[0] < 8));
      chk("done8", 32'(done8), 32'(act[0] && age[0] == 8));
      chk("res8",  32'({cout8, sum8}), 32'(m_res[0]));
      chk("busy4", 32'(busy4), 32'(act[1] && age[1] < 4));
      chk("done4", 32'(done4), 32'(act[1] && age[1] == 4));
      chk("res4",  32'({cout4, sum4}), 32'(m_res[1]));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf8",  32'(ovf8), 32'(m_ovf[0]));
      chk("ovf4",  32'(ovf4), 32'(m_ovf[1]));
`endif
    end
  end

  // Pulse start for one cycle on instance i; inputs are scrambled afterwards.
  task automatic issue(int i, logic [7:0] x, logic [7:0] y, logic c);
    st[i] = 1'b1;
    av[i] = x;
    bv[i] = y;
    cv[i] = c;
    @(negedge clk);
    st[i] = 1'b0;
    av[i] = (i == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
    bv[i] = (i == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
    cv[i] = 1'($urandom);
  endtask

  task automatic run8(logic [7:0] x, logic [7:0] y, logic c);
    issue(0, x, y, c);
    repeat (9) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; cv[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_res",  32'({cout8, sum8}), 32'h000);
    @(negedge clk);

    run8(8'h00, 8'h00, 1'b0);
    chk("v1_res", 32'({cout8, sum8}), 32'h000);

    run8(8'hFF, 8'h01, 1'b0);
    chk("v2_res", 32'({cout8, sum8}), 32'h100);
    chk("v2_model", 32'(m_res[0]), 32'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("v2_ovf", 32'(ovf8), 32'd0);
`endif

    run8(8'hA5, 8'h5A, 1'b1);
    chk("v3_res", 32'({cout8, sum8}), 32'h100);

    run8(8'h7F, 8'h01, 1'b0);
    chk("v4_res", 32'({cout8, sum8}), 32'h080);
    chk("v4_model", 32'(m_res[0]), 32'h080);
`ifdef SERIAL_ADDER_OVF_EN
    chk("v4_ovf", 32'(ovf8), 32'd1);
`endif

    // Starts during SHIFT must be dropped: 0x3C + 0x0F + 1 = 0x4C.
    issue(0, 8'h3C, 8'h0F, 1'b1);
    repeat (2) @(negedge clk);
    st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF; cv[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h80; bv[0] = 8'h80; cv[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    chk("ign_done", 32'(done8), 32'd1);
    @(negedge clk);
    chk("ign_res", 32'({cout8, sum8}), 32'h04C);
    run8(8'h01, 8'h02, 1'b0);
    chk("after_ign_res", 32'({cout8, sum8}), 32'h003);

    // Reset in the middle of SHIFT.
    issue(0, 8'hEE, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    chk("mid_rst_res",  32'({cout8, sum8}), 32'h000);
    @(negedge clk);
    chk("mid_rst_idle", 32'(busy8), 32'd0);
    run8(8'h12, 8'h34, 1'b0);
    chk("post_rst_res", 32'({cout8, sum8}), 32'h046);

    // Exhaustive WIDTH=4.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          issue(1, 8'(x), 8'(y), 1'(c));
          repeat (5) @(negedge clk);
          chk($sformatf("exh_%0d_%0d_%0d", x, y, c), 32'({cout4, sum4}), 32'(x + y + c));
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
